// File: rtl/mem_arb_pkg.sv
// Shared types for the RAM port arbiter:
// FSM states, grant IDs and default widths.
package mem_arb_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_WAIT,
    S_DONE
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;
endpackage

// File: rtl/mem_arb_pick.sv
// 2-way request picker. Ties go to data, or alternate when MEM_ARB_RR_EN is defined.
// Ports: if_req, d_req, last_grant in; any, gnt out.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  gnt_t last_grant,
  output logic any,
  output gnt_t gnt
);

`ifdef MEM_ARB_RR_EN
  gnt_t tie_gnt;
  assign tie_gnt = (last_grant == GNT_D) ? GNT_IF : GNT_D;
`else
  gnt_t tie_gnt;
  logic unused_lg;
  assign tie_gnt   = GNT_D;
  assign unused_lg = last_grant;
`endif

  always_comb begin
    any = if_req | d_req;
    gnt = GNT_IF;
    unique case (1'b1)
      (if_req & d_req):  gnt = tie_gnt;
      (d_req & ~if_req): gnt = GNT_D;
      (if_req & ~d_req): gnt = GNT_IF;
      default:           gnt = GNT_IF;
    endcase
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between fetch and load/store; returns held rdata.
// Ports: if_*, d_* requesters; ram_* RAM side; busy. Macro: MEM_ARB_RR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic [DW-1:0] ram_data,
  output logic [AW-1:0] ram_rdaddr,
  output logic [AW-1:0] ram_wraddr,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q,
  output logic          busy
);

  localparam int CW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  state_t        state, state_nx;
  gnt_t          gnt_q, last_grant, pick_gnt;
  logic          pick_any;
  logic          we_q;
  logic [CW-1:0] cnt;

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .any        (pick_any),
    .gnt        (pick_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // DONE never samples requests, so a held req is not served twice
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (pick_any) state_nx = S_ACC;
      S_ACC:   state_nx = we_q ? S_DONE : S_WAIT;
      S_WAIT:  if (cnt == CW'(1)) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q      <= GNT_IF;
      last_grant <= GNT_IF;
      we_q       <= 1'b0;
      cnt        <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      ram_data   <= '0;
      ram_rdaddr <= '0;
      ram_wraddr <= '0;
      ram_wren   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pick_any) begin
            gnt_q      <= pick_gnt;
            last_grant <= pick_gnt;
            if (pick_gnt == GNT_D) begin
              we_q       <= d_we;
              ram_wren   <= d_we;
              ram_rdaddr <= d_we ? '0 : d_addr;
              ram_wraddr <= d_we ? d_addr : '0;
              ram_data   <= d_we ? d_wdata : '0;
            end else begin
              we_q       <= 1'b0;
              ram_wren   <= 1'b0;
              ram_rdaddr <= if_addr;
              ram_wraddr <= '0;
              ram_data   <= '0;
            end
          end
        end
        S_ACC: begin
          ram_wren <= 1'b0;
          cnt      <= CW'(RD_LAT);
        end
        S_WAIT: begin
          if (cnt == CW'(1)) begin
            if (gnt_q == GNT_D) d_rdata  <= ram_q;
            else                if_rdata <= ram_q;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign if_done = (state == S_DONE) && (gnt_q == GNT_IF);
  assign d_done  = (state == S_DONE) && (gnt_q == GNT_D);
  assign busy    = (state != S_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (RD_LAT=1 instance plus RD_LAT=3 instance).
// Honours MEM_ARB_RR_EN for tie-order expectations.
module tb_mem_port_arbiter;
  typedef struct {
    bit          is_d;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 0, d_req = 0, d_we = 0;
  logic [7:0]  if_addr = 0, d_addr = 0;
  logic [31:0] d_wdata = 0;
  logic        if_done, d_done, ram_wren, busy;
  logic [31:0] if_rdata, d_rdata, ram_data, ram_q;
  logic [7:0]  ram_rdaddr, ram_wraddr;

  logic        if_req3 = 0;
  logic [7:0]  if_addr3 = 0;
  logic        if_done3, d_done3, ram_wren3, busy3;
  logic [31:0] if_rdata3, d_rdata3, ram_data3;
  logic [7:0]  ram_rdaddr3, ram_wraddr3;
  logic [31:0] p0, p1, p2;

  logic        pre_we = 0;
  logic [7:0]  pre_addr = 0;
  logic [31:0] pre_data = 0;
  logic [31:0] mem  [256];
  logic [31:0] mem3 [256];

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(8), .DW(32), .RD_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .ram_data(ram_data), .ram_rdaddr(ram_rdaddr),
    .ram_wraddr(ram_wraddr), .ram_wren(ram_wren),
    .ram_q(ram_q), .busy(busy)
  );

  mem_port_arbiter #(.AW(8), .DW(32), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req3), .if_addr(if_addr3),
    .if_done(if_done3), .if_rdata(if_rdata3),
    .d_req(1'b0), .d_we(1'b0), .d_addr(8'h00), .d_wdata(32'h0),
    .d_done(d_done3), .d_rdata(d_rdata3),
    .ram_data(ram_data3), .ram_rdaddr(ram_rdaddr3),
    .ram_wraddr(ram_wraddr3), .ram_wren(ram_wren3),
    .ram_q(p2), .busy(busy3)
  );

  always @(posedge clk) begin
    if (ram_wren) mem[ram_wraddr] <= ram_data;
    else if (pre_we) mem[pre_addr] <= pre_data;
    ram_q <= mem[ram_rdaddr];
  end

  always @(posedge clk) begin
    if (ram_wren3) mem3[ram_wraddr3] <= ram_data3;
    else if (pre_we) mem3[pre_addr] <= pre_data;
    p0 <= mem3[ram_rdaddr3];
    p1 <= p0;
    p2 <= p1;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (if_done || d_done)) begin
      check("one_done", 32'(if_done & d_done), 32'h0);
      if (sbq.size() == 0) begin
        check("unexpected_done", 32'(d_done), 32'h2);
      end else begin
        e = sbq.pop_front();
        check("done_who", 32'(d_done), 32'(e.is_d));
        if (e.chk)
          check("rdata", d_done ? d_rdata : if_rdata, e.data);
      end
    end
  end

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 0;
  endtask

  task automatic access(input bit is_d, input bit we, input logic [7:0] a,
                        input logic [31:0] wd, input int exp_lat,
                        input logic [31:0] exp_d, input int drop_at);
    int c;
    int wr;
    bit got;
    @(negedge clk);
    if (is_d) begin
      d_req = 1; d_we = we; d_addr = a; d_wdata = wd;
    end else begin
      if_req = 1; if_addr = a;
    end
    sbq.push_back('{is_d, !we, exp_d});
    c = 1; wr = 0; got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (c == 1) begin
        if (we) begin
          check("acc_wraddr", 32'(ram_wraddr), 32'(a));
          check("acc_wdata", ram_data, wd);
        end else begin
          check("acc_rdaddr", 32'(ram_rdaddr), 32'(a));
        end
      end
      if (ram_wren) wr++;
      if (c == drop_at) begin
        if_req = 0; d_req = 0;
      end
      if (is_d ? d_done : if_done) begin
        got = 1;
        break;
      end
      c++;
    end
    if_req = 0; d_req = 0; d_we = 0;
    check("latency", got ? 32'(c) : 32'hFFFF_FFFF, 32'(exp_lat));
    check("wren_cycles", 32'(wr), we ? 32'd1 : 32'd0);
  endtask

  // Both requesters raised together; each optionally drops on its own done,
  // and both drop once `total` accesses have completed.
  task automatic tie_run(input int total, input bit drop_own);
    int n;
    n = 0;
    @(negedge clk);
    if_req = 1; if_addr = 8'h30;
    d_req = 1; d_we = 0; d_addr = 8'h31;
    for (int k = 0; k < 80 && (if_req || d_req); k++) begin
      @(negedge clk);
      if (if_done || d_done) begin
        n++;
        if (drop_own && d_done) d_req = 0;
        if (drop_own && if_done) if_req = 0;
        if (n == total) begin
          if_req = 0; d_req = 0;
        end
      end
    end
    check("tie_count", 32'(n), 32'(total));
    if_req = 0; d_req = 0;
  endtask

  initial begin
    int c;
    bit got;
    #12;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_wren", 32'(ram_wren), 32'h0);
    check("rst_ifr", if_rdata, 32'h0);
    check("rst_dr", d_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1;

    // Reset during a store's ACC cycle
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 8'h40; d_wdata = 32'h5555_AAAA;
    @(negedge clk);
    check("abort_wren_pre", 32'(ram_wren), 32'h1);
    #1 rst_n = 0;
    #1;
    check("abort_wren", 32'(ram_wren), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_wraddr", 32'(ram_wraddr), 32'h0);
    check("abort_data", ram_data, 32'h0);
    check("abort_done", 32'(d_done), 32'h0);
    d_req = 0; d_we = 0;
    @(negedge clk);
    rst_n = 1;

    preload(8'h10, 32'hDEAD_BEEF);
    preload(8'h30, 32'h1111_1111);
    preload(8'h31, 32'h2222_2222);
    preload(8'h20, 32'hCAFE_F00D);

    // Store then load at 0xFF
    access(1, 1, 8'hFF, 32'h1234_5678, 2, 32'h0, -1);
    access(1, 0, 8'hFF, 32'h0, 3, 32'h1234_5678, -1);
    check("ifr_untouched", if_rdata, 32'h0);

    // Fetch, rdata held after req drops
    access(0, 0, 8'h10, 32'h0, 3, 32'hDEAD_BEEF, -1);
    repeat (3) @(negedge clk);
    check("ifr_held", if_rdata, 32'hDEAD_BEEF);
    check("dr_held", d_rdata, 32'h1234_5678);

    // Simple tie: data first, fetch next
    sbq.push_back('{1, 1, 32'h2222_2222});
    sbq.push_back('{0, 1, 32'h1111_1111});
    tie_run(2, 1);

    // Continuous tie: fixed D,D,D,D; round-robin D,IF,D,IF
`ifdef MEM_ARB_RR_EN
    for (int i = 0; i < 4; i++)
      sbq.push_back('{(i % 2) == 0, 1,
                      (i % 2) == 0 ? 32'h2222_2222 : 32'h1111_1111});
`else
    for (int i = 0; i < 4; i++)
      sbq.push_back('{1, 1, 32'h2222_2222});
`endif
    tie_run(4, 0);

    // Req dropped in WAIT: done still pulses, nothing further
    access(0, 0, 8'h30, 32'h0, 3, 32'h1111_1111, 2);
    repeat (6) @(negedge clk);
    check("busy_idle", 32'(busy), 32'h0);

    // RD_LAT=3 instance: fetch done in cycle 5
    @(negedge clk);
    if_req3 = 1; if_addr3 = 8'h20;
    c = 1; got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if_done3) begin
        got = 1;
        break;
      end
      c++;
    end
    if_req3 = 0;
    check("lat3", got ? 32'(c) : 32'hFFFF_FFFF, 32'd5);
    check("lat3_rdata", if_rdata3, 32'hCAFE_F00D);
    repeat (3) @(negedge clk);
    check("lat3_busy", 32'(busy3), 32'h0);

    check("sb_empty", 32'(sbq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
